video_timing_generator: RTL and testbench

Raster timing source for the SXGA060 OLED test-image path. Counts pixel clocks into lines and frames and emits registered `x`, `y`, `DE`, `HSync`, `VSync` and a frame-start strobe, which feed `test_screens_generator` directly. Also owns the `ImageState` sequencer, so pattern changes happen only on frame boundaries, either automatically or on request.

---
 rtl/video_timing_generator_pkg.sv | 45 ++++
 rtl/video_timing_generator_image_state_sequencer.sv | 67 ++++++
 rtl/video_timing_generator.sv | 112 +++++++++++
 tb/tb_video_timing_generator.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/video_timing_generator_pkg.sv
// Shared types and constants for the raster timing generator and its pattern sequencer.
package video_timing_generator_pkg;

  localparam int unsigned WIDTH  = 1280;
  localparam int unsigned HEIGHT = 1024;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned IMG_W  = 4;
  localparam int unsigned FCNT_W = 8;

  // 12'hfff is reserved as the "outside active region" coordinate
  localparam logic [CNT_W-1:0] COORD_BLANK = 12'hfff;

  localparam logic [IMG_W-1:0] IMAGE_STATE_0 = 4'b0001;
  localparam logic [IMG_W-1:0] IMAGE_STATE_1 = 4'b0010;
  localparam logic [IMG_W-1:0] IMAGE_STATE_2 = 4'b0100;
  localparam logic [IMG_W-1:0] IMAGE_STATE_3 = 4'b1000;

  typedef logic [CNT_W-1:0] coord_t;
  typedef logic [IMG_W-1:0] image_state_t;

  // Registered timing payload handed to the test-screen generator
  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   de;
    logic   hsync;
    logic   vsync;
    logic   frame_start;
  } timing_t;

  // Next pattern in the rotation; any illegal encoding recovers to the first pattern
  function automatic image_state_t next_image_state(input image_state_t s);
    image_state_t r;
    case (s)
      IMAGE_STATE_0: r = IMAGE_STATE_1;
      IMAGE_STATE_1: r = IMAGE_STATE_2;
      IMAGE_STATE_2: r = IMAGE_STATE_3;
      IMAGE_STATE_3: r = IMAGE_STATE_0;
      default:       r = IMAGE_STATE_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/video_timing_generator_image_state_sequencer.sv
// Pattern sequencer: rotates the one-hot image select only on frame-start edges,
// either every FRAMES_PER_IMAGE frames or on a (collapsed) manual request.
module video_timing_generator_image_state_sequencer
  import video_timing_generator_pkg::*;
#(
  parameter int unsigned FRAMES_PER_IMAGE = 120
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_boundary,
  input  logic             i_auto_cycle,
  input  logic             i_next_image,
  output logic [IMG_W-1:0] o_image_state
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_IMAGE - 1);

  image_state_t      r_image_state, w_image_state;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt;
  logic              r_pending, w_pending;
  logic              r_started, w_started;
  logic              w_advance;

  // Next-state: the first boundary after reset opens frame 0 of the current
  // pattern, so it only honours a manual request and never counts as an elapsed frame
  always_comb begin
    w_image_state = r_image_state;
    w_fcnt        = r_fcnt;
    w_pending     = r_pending;
    w_started     = r_started;
    w_advance     = 1'b0;
    if (i_boundary) begin
      w_started = 1'b1;
      w_advance = r_pending || i_next_image ||
                  (i_auto_cycle && r_started && (r_fcnt == FCNT_LAST));
      if (w_advance) begin
        w_image_state = next_image_state(r_image_state);
        w_pending     = 1'b0;
        w_fcnt        = '0;
      end else if (i_auto_cycle && r_started) begin
        w_fcnt = r_fcnt + 1'b1;
      end else begin
        w_fcnt = '0;
      end
    end else if (i_next_image) begin
      w_pending = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_image_state <= IMAGE_STATE_0;
      r_fcnt        <= '0;
      r_pending     <= 1'b0;
      r_started     <= 1'b0;
    end else begin
      r_image_state <= w_image_state;
      r_fcnt        <= w_fcnt;
      r_pending     <= w_pending;
      r_started     <= w_started;
    end
  end

  assign o_image_state = r_image_state;

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source: pixel/line counters, registered coordinates, DE, syncs,
// frame-start strobe, and the frame-aligned pattern sequencer.
module video_timing_generator
  import video_timing_generator_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = WIDTH,
  parameter int unsigned H_FP             = 48,
  parameter int unsigned H_SYNC           = 112,
  parameter int unsigned H_BP             = 248,
  parameter int unsigned V_ACTIVE         = HEIGHT,
  parameter int unsigned V_FP             = 1,
  parameter int unsigned V_SYNC           = 3,
  parameter int unsigned V_BP             = 38,
  parameter logic        SYNC_POL         = 1'b0,
  parameter int unsigned FRAMES_PER_IMAGE = 120
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        AutoCycle,
  input  logic        NextImage,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        DE,
  output logic        HSync,
  output logic        VSync,
  output logic        FrameStart,
  output logic [3:0]  ImageState
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam timing_t OUT_RST = '{
    x:           COORD_BLANK,
    y:           COORD_BLANK,
    de:          1'b0,
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    frame_start: 1'b0
  };

  coord_t  r_hcnt, r_vcnt;
  timing_t r_out, w_out;
  logic    w_hwrap, w_vwrap;
  logic    w_h_active, w_v_active;
  logic    w_hsync_on, w_vsync_on;
  logic    w_boundary;

  assign w_hwrap    = (r_hcnt == CNT_W'(H_TOTAL - 1));
  assign w_vwrap    = (r_vcnt == CNT_W'(V_TOTAL - 1));
  assign w_h_active = (r_hcnt < CNT_W'(H_ACTIVE));
  assign w_v_active = (r_vcnt < CNT_W'(V_ACTIVE));
  assign w_hsync_on = (r_hcnt >= CNT_W'(H_SYNC_START)) && (r_hcnt < CNT_W'(H_SYNC_END));
  assign w_vsync_on = (r_vcnt >= CNT_W'(V_SYNC_START)) && (r_vcnt < CNT_W'(V_SYNC_END));
  assign w_boundary = (r_hcnt == '0) && (r_vcnt == '0);

  // Pixel and line counters; the line counter steps when the pixel counter wraps
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_hwrap ? '0 : r_hcnt + 1'b1;
      if (w_hwrap) begin
        r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
      end
    end
  end

  // Decode the current counter position into the timing payload
  always_comb begin
    w_out             = OUT_RST;
    w_out.x           = w_h_active ? r_hcnt : COORD_BLANK;
    w_out.y           = w_v_active ? r_vcnt : COORD_BLANK;
    w_out.de          = w_h_active && w_v_active;
    w_out.hsync       = w_hsync_on ? SYNC_POL : ~SYNC_POL;
    w_out.vsync       = w_vsync_on ? SYNC_POL : ~SYNC_POL;
    w_out.frame_start = w_boundary;
  end

  // Output register: every timing output lags its counter state by one clock
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_out <= OUT_RST;
    end else begin
      r_out <= w_out;
    end
  end

  assign x          = r_out.x;
  assign y          = r_out.y;
  assign DE         = r_out.de;
  assign HSync      = r_out.hsync;
  assign VSync      = r_out.vsync;
  assign FrameStart = r_out.frame_start;

  video_timing_generator_image_state_sequencer #(
    .FRAMES_PER_IMAGE (FRAMES_PER_IMAGE)
  ) u_seq (
    .i_clk         (Clock),
    .i_rst         (Reset),
    .i_boundary    (w_boundary),
    .i_auto_cycle  (AutoCycle),
    .i_next_image  (NextImage),
    .o_image_state (ImageState)
  );

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator with a 14x7 raster (98 clocks per frame).
module tb_video_timing_generator;

  localparam logic [11:0] BLANK = 12'hfff;
  localparam int H_TOT = 14;
  localparam int V_TOT = 7;
  localparam int FRAME = H_TOT * V_TOT;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        AutoCycle = 1'b0;
  logic        NextImage = 1'b0;
  logic [11:0] x, y;
  logic        DE, HSync, VSync, FrameStart;
  logic [3:0]  ImageState;

  int n_checks = 0;
  int n_errors = 0;

  video_timing_generator #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0), .FRAMES_PER_IMAGE (2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .AutoCycle  (AutoCycle),
    .NextImage  (NextImage),
    .x          (x),
    .y          (y),
    .DE         (DE),
    .HSync      (HSync),
    .VSync      (VSync),
    .FrameStart (FrameStart),
    .ImageState (ImageState)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] r;
    r = 4'b0001 << idx;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".x"},  16'(x), 16'(BLANK));
    check({tag, ".y"},  16'(y), 16'(BLANK));
    check({tag, ".de"}, 16'(DE), 16'd0);
    check({tag, ".fs"}, 16'(FrameStart), 16'd0);
    check({tag, ".hs"}, 16'(HSync), 16'd1);
    check({tag, ".vs"}, 16'(VSync), 16'd1);
    check({tag, ".img"}, 16'(ImageState), 16'h1);
  endtask

  // Expected raster outputs for the k-th edge after reset release
  task automatic check_pos(input int k);
    int h, v;
    logic [11:0] ex, ey;
    h  = k % H_TOT;
    v  = (k / H_TOT) % V_TOT;
    ex = (h < 8) ? 12'(h) : BLANK;
    ey = (v < 4) ? 12'(v) : BLANK;
    check($sformatf("x@%0d", k),  16'(x), 16'(ex));
    check($sformatf("y@%0d", k),  16'(y), 16'(ey));
    check($sformatf("de@%0d", k), 16'(DE), 16'((h < 8) && (v < 4)));
    check($sformatf("hs@%0d", k), 16'(HSync), 16'(!((h >= 10) && (h < 12))));
    check($sformatf("vs@%0d", k), 16'(VSync), 16'(v != 5));
    check($sformatf("fs@%0d", k), 16'(FrameStart), 16'((k % FRAME) == 0));
  endtask

  // Run n edges from release; NextImage asserted on edges ni0..ni2.
  // auto: expected pattern index = frame/2; else idx0 before switch_k, idx1 from it.
  task automatic run(input int n, input int ni0, input int ni1, input int ni2,
                     input bit auto, input int idx0, input int idx1, input int switch_k);
    int idx;
    for (int k = 0; k < n; k++) begin
      NextImage = (k == ni0) || (k == ni1) || (k == ni2);
      tick();
      NextImage = 1'b0;
      check_pos(k);
      if (auto) idx = (k / (2 * FRAME)) % 4;
      else      idx = (k >= switch_k) ? idx1 : idx0;
      check($sformatf("img@%0d", k), 16'(ImageState), 16'(onehot(idx)));
    end
  endtask

  initial begin
    // Reset values, then auto rotation over nine frames
    Reset = 1'b1;
    AutoCycle = 1'b1;
    repeat (3) tick();
    check_reset("rst0");
    Reset = 1'b0;
    run(9 * FRAME, -1, -1, -1, 1'b1, 0, 0, 0);

    // Three manual requests in one frame collapse to one advance
    Reset = 1'b1;
    AutoCycle = 1'b0;
    tick();
    check_reset("rst1");
    Reset = 1'b0;
    run(3 * FRAME + 1, 20, 30, 40, 1'b0, 0, 1, FRAME);

    // Manual request on the boundary where auto is already due
    Reset = 1'b1;
    AutoCycle = 1'b1;
    tick();
    check_reset("rst2");
    Reset = 1'b0;
    run(5 * FRAME + 1, 2 * FRAME, -1, -1, 1'b1, 0, 0, 0);

    // Request on the first edge, then reset mid-frame at line 2, x=5
    Reset = 1'b1;
    AutoCycle = 1'b0;
    tick();
    check_reset("rst3");
    Reset = 1'b0;
    run(2 * H_TOT + 6, 0, -1, -1, 1'b0, 1, 1, 0);
    check("mid.x", 16'(x), 16'd5);
    check("mid.y", 16'(y), 16'd2);
    Reset = 1'b1;
    tick();
    check_reset("rst4");
    Reset = 1'b0;
    run(FRAME + 1, -1, -1, -1, 1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
